// File: rtl/mac_rx_fifo_wr.sv
// rtl/mac_rx_fifo_wr.sv - MAC RX FIFO write side: byte packing, frame commit/rewind, Gray write pointer.
// Optional frame/drop counters enabled by MAC_RX_FIFO_STATS_EN.
module mac_rx_fifo_wr #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clkA,
  input  logic          resetnB,
  input  logic          iValid,
  input  logic [7:0]    iData,
  input  logic          iSof,
  input  logic          iEof,
  input  logic          iErr,
  output logic          oWrA,
  output logic [AW-1:0] oAddrA,
  output logic [DW-1:0] oDataA,
  input  logic [AW:0]   iRdPtrGray,
  output logic [AW:0]   oWrPtrGray,
  output logic          oFull,
  output logic          oDrop
`ifdef MAC_RX_FIFO_STATS_EN
  ,
  output logic [15:0]   oFrmCnt,
  output logic [15:0]   oDropCnt
`endif
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          drop_q, drop_d;
  logic [AW:0]   wr_work_q, wr_work_d;
  logic [AW:0]   wr_commit_q, wr_commit_d;
  logic [AW:0]   gray_q;
  logic [AW:0]   rd_sync1_q, rd_sync2_q;
  logic [AW:0]   rd_bin;

  logic          start, take, rewind, due, full_due;
  logic [1:0]    cur_lane;
  logic [DW-1:0] cur_acc, merged;
  logic [AW:0]   base;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign rd_bin     = gray2bin(rd_sync2_q);
  assign oFull      = (wr_work_q - rd_bin) == DEPTH;
  assign oAddrA     = wr_work_q[AW-1:0];
  assign oDataA     = data_q;
  assign oWrA       = wr_q;
  assign oDrop      = drop_q;
  assign oWrPtrGray = gray_q;

  // base is where the next word would land once any in-flight write retires
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    drop_d      = 1'b0;
    wr_commit_d = wr_commit_q;
    base        = wr_work_q + {{AW{1'b0}}, wr_q};
    start       = 1'b0;
    take        = 1'b0;
    rewind      = 1'b0;

    if (iValid) begin
      case (state_q)
        IDLE: begin
          if (iSof) begin
            start = 1'b1;
            take  = 1'b1;
          end
        end
        FRAME, DROP: begin
          if (iSof) begin
            rewind = 1'b1;
            drop_d = 1'b1;
            start  = 1'b1;
            take   = 1'b1;
          end else if (state_q == FRAME) begin
            take = 1'b1;
          end else if (iEof) begin
            rewind  = 1'b1;
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (rewind) base = wr_commit_q;
    wr_work_d = base;

    cur_lane = start ? 2'd0 : lane_q;
    cur_acc  = start ? '0 : acc_q;
    merged   = cur_acc | (DW'(iData) << {cur_lane, 3'b000});
    due      = (cur_lane == 2'd3) || iEof;
    full_due = (base - rd_bin) == DEPTH;

    if (take) begin
      state_d = FRAME;
      if (iEof && iErr) begin
        wr_work_d = wr_commit_q;
        drop_d    = 1'b1;
        state_d   = IDLE;
        lane_d    = 2'd0;
        acc_d     = '0;
      end else if (due) begin
        lane_d = 2'd0;
        acc_d  = '0;
        if (full_due) begin
          if (iEof) begin
            wr_work_d = wr_commit_q;
            drop_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = DROP;
          end
        end else begin
          wr_d   = 1'b1;
          data_d = merged;
          if (iEof) begin
            wr_commit_d = base + 1'b1;
            state_d     = IDLE;
          end
        end
      end else begin
        lane_d = cur_lane + 2'd1;
        acc_d  = merged;
      end
    end
  end

  always_ff @(posedge clkA or negedge resetnB) begin
    if (!resetnB) begin
      state_q     <= IDLE;
      lane_q      <= 2'd0;
      acc_q       <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      drop_q      <= 1'b0;
      wr_work_q   <= '0;
      wr_commit_q <= '0;
      gray_q      <= '0;
      rd_sync1_q  <= '0;
      rd_sync2_q  <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      drop_q      <= drop_d;
      wr_work_q   <= wr_work_d;
      wr_commit_q <= wr_commit_d;
      gray_q      <= wr_commit_q ^ (wr_commit_q >> 1);
      rd_sync1_q  <= iRdPtrGray;
      rd_sync2_q  <= rd_sync1_q;
    end
  end

`ifdef MAC_RX_FIFO_STATS_EN
  // Commit always advances the pointer, so a change marks a committed frame
  always_ff @(posedge clkA or negedge resetnB) begin
    if (!resetnB) begin
      oFrmCnt  <= 16'h0000;
      oDropCnt <= 16'h0000;
    end else begin
      if ((wr_commit_d != wr_commit_q) && (oFrmCnt != 16'hFFFF)) oFrmCnt <= oFrmCnt + 16'h0001;
      if (drop_d && (oDropCnt != 16'hFFFF)) oDropCnt <= oDropCnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_mac_rx_fifo_wr.sv
// tb/tb_mac_rx_fifo_wr.sv - directed self-checking bench for mac_rx_fifo_wr.
module tb_mac_rx_fifo_wr;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clkA = 1'b0;
  logic          resetnB;
  logic          iValid, iSof, iEof, iErr;
  logic [7:0]    iData;
  logic          oWrA, oFull, oDrop;
  logic [AW-1:0] oAddrA;
  logic [DW-1:0] oDataA;
  logic [AW:0]   iRdPtrGray, oWrPtrGray;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            drops;
  logic          full_seen;
  logic [7:0]    frm[$];

  mac_rx_fifo_wr #(.AW(AW), .DW(DW)) dut (
    .clkA(clkA), .resetnB(resetnB), .iValid(iValid), .iData(iData),
    .iSof(iSof), .iEof(iEof), .iErr(iErr), .oWrA(oWrA), .oAddrA(oAddrA),
    .oDataA(oDataA), .iRdPtrGray(iRdPtrGray), .oWrPtrGray(oWrPtrGray),
    .oFull(oFull), .oDrop(oDrop)
  );

  always #5 clkA = ~clkA;

  always @(negedge clkA) begin
    if (resetnB) begin
      if (oWrA) begin
        wa.push_back(oAddrA);
        wd.push_back(oDataA);
      end
      if (oDrop) drops++;
      if (oFull) full_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    drops     = 0;
    full_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clkA);
    resetnB = 1'b0;
    iValid = 1'b0; iSof = 1'b0; iEof = 1'b0; iErr = 1'b0; iData = 8'h00;
    repeat (2) @(posedge clkA);
    @(negedge clkA);
    resetnB = 1'b1;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof, input logic err);
    @(negedge clkA);
    iValid = 1'b1; iData = d; iSof = sof; iEof = eof; iErr = err;
    @(posedge clkA);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clkA);
    iValid = 1'b0; iSof = 1'b0; iEof = 1'b0; iErr = 1'b0;
    repeat (n) @(posedge clkA);
    #1;
  endtask

  task automatic send_frame(input logic with_eof, input logic err);
    for (int i = 0; i < frm.size(); i++)
      send_byte(frm[i], i == 0, with_eof && (i == frm.size() - 1), err && (i == frm.size() - 1));
  endtask

  initial begin
    iRdPtrGray = '0;
    resetnB = 1'b0;
    iValid = 1'b0; iSof = 1'b0; iEof = 1'b0; iErr = 1'b0; iData = 8'h00;
    #3;
    check("reset_wr", oWrA, 0);
    check("reset_gray", oWrPtrGray, 0);
    check("reset_full", oFull, 0);
    check("reset_drop", oDrop, 0);
    check("reset_addr", oAddrA, 0);
    do_reset();

    // 4-byte good frame, then a 1-byte frame
    frm = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1, 0);
    idle(3);
    check("f4_nwr", wa.size(), 1);
    check("f4_addr", wa[0], 0);
    check("f4_data", wd[0], 32'h44332211);
    check("f4_gray", oWrPtrGray, 6'b000001);
    frm = '{8'hAB};
    send_frame(1, 0);
    idle(3);
    check("f1_addr", wa[1], 1);
    check("f1_data", wd[1], 32'h000000AB);
    check("f1_gray", oWrPtrGray, 6'b000011);

    // 6-byte frame with partial last word
    do_reset();
    frm = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(1, 0);
    idle(3);
    check("f6_nwr", wa.size(), 2);
    check("f6_a0", wa[0], 0);
    check("f6_d0", wd[0], 32'h04030201);
    check("f6_a1", wa[1], 1);
    check("f6_d1", wd[1], 32'h00000605);
    check("f6_gray", oWrPtrGray, 6'b000011);

    // errored 8-byte frame is rewound
    clear_log();
    frm = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send_frame(1, 1);
    idle(3);
    check("err_nwr", wa.size(), 1);
    check("err_a0", wa[0], 2);
    check("err_d0", wd[0], 32'hA3A2A1A0);
    check("err_drops", drops, 1);
    check("err_gray", oWrPtrGray, 6'b000011);
    check("err_addr", oAddrA, 2);
    frm = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    send_frame(1, 0);
    idle(3);
    check("aft_addr", wa[1], 2);
    check("aft_data", wd[1], 32'hB3B2B1B0);
    check("aft_gray", oWrPtrGray, 6'b000010);

    // overflow: 140 bytes into a 32-word FIFO with reader at 0
    do_reset();
    frm.delete();
    for (int i = 0; i < 140; i++) frm.push_back(8'(i));
    send_frame(1, 0);
    idle(3);
    check("ovf_nwr", wa.size(), 32);
    check("ovf_last_a", wa[31], 31);
    check("ovf_last_d", wd[31], 32'h7F7E7D7C);
    check("ovf_full_seen", full_seen, 1);
    check("ovf_drops", drops, 1);
    check("ovf_gray", oWrPtrGray, 0);
    check("ovf_full_end", oFull, 0);
    check("ovf_addr", oAddrA, 0);

    // SOF mid-frame after 5 bytes restarts at committed address
    do_reset();
    frm = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_frame(0, 0);
    frm = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    send_frame(1, 0);
    idle(3);
    check("sof_nwr", wa.size(), 2);
    check("sof_a1", wa[1], 0);
    check("sof_d1", wd[1], 32'hD3D2D1D0);
    check("sof_drops", drops, 1);
    check("sof_gray", oWrPtrGray, 6'b000001);

    // reset mid-frame
    frm = '{8'hE0, 8'hE1, 8'hE2};
    send_frame(0, 0);
    #1;
    resetnB = 1'b0;
    #1;
    check("rst_wr", oWrA, 0);
    check("rst_gray", oWrPtrGray, 0);
    check("rst_addr", oAddrA, 0);
    check("rst_drop", oDrop, 0);
    do_reset();
    frm = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
    send_frame(1, 0);
    idle(3);
    check("rst_nwr", wa.size(), 1);
    check("rst_a0", wa[0], 0);
    check("rst_d0", wd[0], 32'hF3F2F1F0);
    check("rst_drops", drops, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
